// File: rtl/video_mem_port_pkg.sv
// Shared types and constants for the video memory port: FSM states, memory
// region decode and display-mode encodings.
package video_mem_port_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_ACK
    } port_state_t;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_VRAM,
        REG_OAM
    } region_t;

    localparam logic [1:0] MODE_HBLANK = 2'b00;
    localparam logic [1:0] MODE_VBLANK = 2'b01;
    localparam logic [1:0] MODE_OAM    = 2'b10;
    localparam logic [1:0] MODE_XFER   = 2'b11;

    localparam logic [15:0] VRAM_BASE = 16'h8000;
    localparam logic [15:0] VRAM_END  = 16'h9FFF;
    localparam logic [15:0] OAM_BASE  = 16'hFE00;
    localparam logic [15:0] OAM_END   = 16'hFE9F;

    // Map a CPU byte address onto the array it selects.
    function automatic region_t decode_region(input logic [15:0] addr);
        region_t r;
        r = REG_NONE;
        if (addr >= VRAM_BASE && addr <= VRAM_END) begin
            r = REG_VRAM;
        end else if (addr >= OAM_BASE && addr <= OAM_END) begin
            r = REG_OAM;
        end
        return r;
    endfunction

    // True when the PPU currently owns the given array.
    function automatic logic region_blocked(input region_t r, input logic [1:0] mode);
        logic b;
        b = 1'b0;
        case (r)
            REG_VRAM: b = (mode == MODE_XFER);
            REG_OAM:  b = (mode == MODE_OAM) || (mode == MODE_XFER);
            default:  b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/video_mem_port_ram.sv
// Single-port byte RAM: synchronous write, combinational read. Addresses at
// or beyond DEPTH read as zero and ignore writes. Contents are never reset.
module video_ram #(
    parameter int unsigned DEPTH = 8192,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];
    logic       in_range;

    assign in_range = (32'(addr) < DEPTH);
    assign rdata    = in_range ? mem[addr] : '0;

    // Byte write on the rising edge.
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/video_mem_port.sv
// Video memory responder: VRAM and OAM arrays shared between the display's
// registered-address read port and an arbitrated CPU port.
// Optional feature macro: VRAM_WRITE_POST_EN (post writes blocked by the PPU
// into a one-entry buffer and drain them when the array frees up).
module video_mem_port
    import video_mem_port_pkg::*;
#(
    parameter int unsigned VRAM_DEPTH = 8192,
    parameter int unsigned OAM_DEPTH  = 160
) (
    input  logic        clk_cpu,
    input  logic        rst_n,
    input  logic [12:0] rd_address_vram,
    input  logic        ld_address_vram,
    input  logic        oe_vram,
    output logic [7:0]  read_data_vram,
    input  logic [7:0]  rd_address_oam,
    input  logic        ld_address_oam,
    input  logic        oe_oam,
    output logic [7:0]  read_data_oam,
    input  logic [1:0]  mode,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack
);

    port_state_t state, state_next;

    logic [12:0] addr_vram_q;
    logic [7:0]  addr_oam_q;

    // Request captured at acceptance; the block decision is frozen here.
    region_t     req_region;
    logic        req_write;
    logic        req_blocked;
    logic [12:0] req_index;
    logic [7:0]  req_wdata;

    // Posted-write buffer; tied off when the feature is disabled.
    logic        buf_valid;
    region_t     buf_region;
    logic [12:0] buf_index;
    logic [7:0]  buf_data;

    region_t     cur_region;
    logic        cur_blocked;
    logic        cur_conflict;
    logic        req_valid;
    logic        drain;
    logic        post_stall;
    logic        accept;
    logic        access_mem;
    logic        access_stall;

    logic [12:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic [7:0]  oam_addr;
    logic        oam_we;
    logic [7:0]  oam_wdata;
    logic [7:0]  oam_rdata;

    assign cpu_ack = (state == S_ACK);

    // Arbitration: decode, conflicts with display reads, drain and acceptance.
    always_comb begin
        cur_region   = decode_region(cpu_addr);
        cur_blocked  = region_blocked(cur_region, mode);
        cur_conflict = ((cur_region == REG_VRAM) && oe_vram) ||
                       ((cur_region == REG_OAM)  && oe_oam);
        req_valid    = cpu_rd ^ cpu_wr;
        drain        = (state == S_IDLE) && buf_valid &&
                       !region_blocked(buf_region, mode) &&
                       !((buf_region == REG_VRAM) ? oe_vram : oe_oam);
        post_stall   = buf_valid && cpu_wr && !cpu_rd && cur_blocked &&
                       (cur_region != REG_NONE);
        accept       = (state == S_IDLE) && req_valid && !cur_conflict &&
                       !drain && !post_stall;
        access_mem   = (state == S_ACCESS) && !req_blocked && (req_region != REG_NONE);
        // A display read that starts mid-access still owns the array, so the
        // CPU access waits in S_ACCESS rather than sharing the address port.
        access_stall = access_mem &&
                       (((req_region == REG_VRAM) && oe_vram) ||
                        ((req_region == REG_OAM)  && oe_oam));
    end

    // CPU FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = S_ACCESS;
            S_ACCESS: if (!access_stall) state_next = S_ACK;
            S_ACK:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // CPU FSM state register.
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Capture the request attributes at acceptance.
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            req_region  <= REG_NONE;
            req_write   <= 1'b0;
            req_blocked <= 1'b0;
            req_index   <= '0;
            req_wdata   <= '0;
        end else if (accept) begin
            req_region  <= cur_region;
            req_write   <= cpu_wr;
            req_blocked <= cur_blocked;
            req_index   <= cpu_addr[12:0];
            req_wdata   <= cpu_wdata;
        end
    end

    // Array port muxes: display read first, then buffer drain, then CPU access.
    always_comb begin
        vram_addr  = addr_vram_q;
        vram_we    = 1'b0;
        vram_wdata = req_wdata;
        oam_addr   = addr_oam_q;
        oam_we     = 1'b0;
        oam_wdata  = req_wdata;
        if (!oe_vram) begin
            if (drain && (buf_region == REG_VRAM)) begin
                vram_addr  = buf_index;
                vram_we    = 1'b1;
                vram_wdata = buf_data;
            end else if (access_mem && (req_region == REG_VRAM)) begin
                vram_addr = req_index;
                vram_we   = req_write;
            end
        end
        if (!oe_oam) begin
            if (drain && (buf_region == REG_OAM)) begin
                oam_addr  = buf_index[7:0];
                oam_we    = 1'b1;
                oam_wdata = buf_data;
            end else if (access_mem && (req_region == REG_OAM)) begin
                oam_addr = req_index[7:0];
                oam_we   = req_write;
            end
        end
    end

    // Display path: address latch and registered read data.
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            addr_vram_q    <= '0;
            addr_oam_q     <= '0;
            read_data_vram <= '0;
            read_data_oam  <= '0;
        end else begin
            if (ld_address_vram) addr_vram_q    <= rd_address_vram;
            if (ld_address_oam)  addr_oam_q     <= rd_address_oam;
            if (oe_vram)         read_data_vram <= vram_rdata;
            if (oe_oam)          read_data_oam  <= oam_rdata;
        end
    end

    // CPU read data, registered at the access edge.
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata <= '0;
        end else if ((state == S_ACCESS) && !access_stall && !req_write) begin
            if (req_blocked || (req_region == REG_NONE)) cpu_rdata <= 8'hFF;
            else if (req_region == REG_VRAM)             cpu_rdata <= vram_rdata;
            else                                         cpu_rdata <= oam_rdata;
        end
    end

`ifdef VRAM_WRITE_POST_EN
    // Posted-write buffer: filled by a blocked write, emptied by a drain.
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid  <= 1'b0;
            buf_region <= REG_NONE;
            buf_index  <= '0;
            buf_data   <= '0;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end else if ((state == S_ACCESS) && req_write && req_blocked &&
                     (req_region != REG_NONE)) begin
            buf_valid  <= 1'b1;
            buf_region <= req_region;
            buf_index  <= req_index;
            buf_data   <= req_wdata;
        end
    end
`else
    assign buf_valid  = 1'b0;
    assign buf_region = REG_NONE;
    assign buf_index  = '0;
    assign buf_data   = '0;
`endif

    video_ram #(.DEPTH(VRAM_DEPTH)) u_vram (
        .clk   (clk_cpu),
        .addr  (vram_addr),
        .we    (vram_we),
        .wdata (vram_wdata),
        .rdata (vram_rdata)
    );

    video_ram #(.DEPTH(OAM_DEPTH)) u_oam (
        .clk   (clk_cpu),
        .addr  (oam_addr),
        .we    (oam_we),
        .wdata (oam_wdata),
        .rdata (oam_rdata)
    );

endmodule
